// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake, pass-through tag and status flags.
// Optional multiplier on opcode 1100 is enabled by defining ALU_PIPE_MUL_EN.
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dataA_i,
    input  logic [WIDTH-1:0] dataB_i,
    input  logic [3:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             illegal_o
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_NOR  = 4'b0100,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRL  = 4'b1010,
        OP_SRA  = 4'b1011,
        OP_MUL  = 4'b1100
    } opcode_e;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
        logic             illegal;
    } stage_t;

    stage_t stage_q [LATENCY];
    stage_t stage_d;

    logic [WIDTH:0]   addFull;
    logic [WIDTH:0]   subFull;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             illegal;
    logic             stall;

    assign addFull = {1'b0, dataA_i} + {1'b0, dataB_i};
    assign subFull = {1'b0, dataA_i} - {1'b0, dataB_i};
    assign shamt   = dataB_i[SHW-1:0];

    // Stage-1 datapath: result and all flags are resolved before the first register
    always_comb begin
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op_i)
            OP_AND:  res = dataA_i & dataB_i;
            OP_OR:   res = dataA_i | dataB_i;
            OP_XOR:  res = dataA_i ^ dataB_i;
            OP_NOR:  res = ~(dataA_i | dataB_i);
            OP_ADD: begin
                res   = addFull[WIDTH-1:0];
                carry = addFull[WIDTH];
                ovf   = (dataA_i[WIDTH-1] == dataB_i[WIDTH-1]) &&
                        (addFull[WIDTH-1] != dataA_i[WIDTH-1]);
            end
            OP_SUB: begin
                res   = subFull[WIDTH-1:0];
                carry = subFull[WIDTH];
                ovf   = (dataA_i[WIDTH-1] != dataB_i[WIDTH-1]) &&
                        (subFull[WIDTH-1] != dataA_i[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(dataA_i) < $signed(dataB_i)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, dataA_i < dataB_i};
            OP_SLL:  res = dataA_i << shamt;
            OP_SRL:  res = dataA_i >> shamt;
            OP_SRA:  res = $unsigned($signed(dataA_i) >>> shamt);
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  res = dataA_i * dataB_i;
`endif
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        stage_d         = '0;
        stage_d.valid   = in_valid_i;
        stage_d.result  = res;
        stage_d.tag     = tag_i;
        stage_d.zero    = ~illegal & (res == '0);
        stage_d.neg     = res[WIDTH-1];
        stage_d.carry   = carry;
        stage_d.ovf     = ovf;
        stage_d.illegal = illegal;
    end

    // A held result freezes the whole pipe, bubbles included
    assign stall      = stage_q[LATENCY-1].valid & ~out_ready_i;
    assign in_ready_o = ~stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i]      <= '0;
                stage_q[i].zero <= 1'b1;
            end
        end else if (!stall) begin
            stage_q[0] <= stage_d;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid_o = stage_q[LATENCY-1].valid;
    assign result_o    = stage_q[LATENCY-1].result;
    assign tag_o       = stage_q[LATENCY-1].tag;
    assign zero_o      = stage_q[LATENCY-1].zero;
    assign neg_o       = stage_q[LATENCY-1].neg;
    assign carry_o     = stage_q[LATENCY-1].carry;
    assign ovf_o       = stage_q[LATENCY-1].ovf;
    assign illegal_o   = stage_q[LATENCY-1].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard testbench for alu_pipe (WIDTH=32, LATENCY=2); honours ALU_PIPE_MUL_EN.
module tb_alu_pipe;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 4;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] dataA_i;
    logic [WIDTH-1:0] dataB_i;
    logic [3:0]       op_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [WIDTH-1:0] result_o;
    logic [TAG_W-1:0] tag_o;
    logic             zero_o;
    logic             neg_o;
    logic             carry_o;
    logic             ovf_o;
    logic             illegal_o;

    alu_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .dataA_i     (dataA_i),
        .dataB_i     (dataB_i),
        .op_i        (op_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .zero_o      (zero_o),
        .neg_o       (neg_o),
        .carry_o     (carry_o),
        .ovf_o       (ovf_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  tag;
        logic [4:0]  flags;
        bit          checkLat;
        int          dueCycle;
    } exp_t;

    exp_t        sbQ[$];
    int          vecCount = 0;
    int          errCount = 0;
    int          cycle = 0;
    int          stallStart = 1000000;
    int          stallEnd = -1;
    logic [41:0] held;
    bit          holdValid = 0;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", name, observed, expected, cycle);
        end
    endtask

    // Flags packed as {zero, neg, carry, ovf, illegal}
    function automatic exp_t modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] tag);
        exp_t            e;
        logic [31:0]     r;
        logic            c;
        logic            v;
        logic            ill;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned tmp;
        longint          sa;
        longint          sb;
        longint          s;
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = 32'd0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                tmp = ua + ub;
                r   = tmp[31:0];
                c   = tmp[32];
                s   = sa + sb;
                v   = (s > MAXS) || (s < MINS);
            end
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd6: begin
                r = a - b;
                c = (ua < ub);
                s = sa - sb;
                v = (s > MAXS) || (s < MINS);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd9:  r = a << b[4:0];
            4'd10: r = a >> b[4:0];
            4'd11: begin
                r = a;
                for (int k = 0; k < int'(b[4:0]); k++) r = {r[31], r[31:1]};
            end
`ifdef ALU_PIPE_MUL_EN
            4'd12: begin
                tmp = ua * ub;
                r   = tmp[31:0];
            end
`endif
            default: ill = 1'b1;
        endcase
        e.result   = r;
        e.tag      = tag;
        e.flags    = {~ill & (r == 32'd0), r[31], c, v, ill};
        e.checkLat = 0;
        e.dueCycle = 0;
        return e;
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag, input bit lat);
        exp_t e;
        int   waitCnt;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        op_i       = op;
        dataA_i    = a;
        dataB_i    = b;
        tag_i      = tag;
        #1;
        waitCnt = 0;
        while (!in_ready_o && waitCnt < 50) begin
            @(negedge clk_i);
            #1;
            waitCnt++;
        end
        if (!in_ready_o) begin
            checkOutput("acceptTimeout", {63'd0, in_ready_o}, 64'd1);
            in_valid_i = 1'b0;
            return;
        end
        e          = modelOp(op, a, b, tag);
        e.checkLat = lat;
        e.dueCycle = cycle + LATENCY;
        sbQ.push_back(e);
        @(posedge clk_i);
    endtask

    task automatic idle();
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        checkOutput("drain", 64'(sbQ.size()), 64'd0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "Valid"}, {63'd0, out_valid_o}, 64'd0);
        checkOutput({name, "Result"}, {32'd0, result_o}, 64'd0);
        checkOutput({name, "Tag"}, {60'd0, tag_o}, 64'd0);
        checkOutput({name, "Flags"}, {59'd0, zero_o, neg_o, carry_o, ovf_o, illegal_o}, 64'b10000);
    endtask

    always @(negedge clk_i) begin
        out_ready_i = !(cycle >= stallStart && cycle <= stallEnd);
    end

    always @(negedge clk_i) begin
        logic [41:0] headNow;
        exp_t        e;
        #2;
        headNow = {out_valid_o, result_o, tag_o, zero_o, neg_o, carry_o, ovf_o, illegal_o};
        if (rst_i) begin
            holdValid = 0;
        end else begin
            if (holdValid) checkOutput("holdStable", {22'd0, headNow}, {22'd0, held});
            holdValid = 0;
            if (out_valid_o) begin
                if (!out_ready_i) begin
                    checkOutput("inReadyStall", {63'd0, in_ready_o}, 64'd0);
                    held      = headNow;
                    holdValid = 1;
                end else if (sbQ.size() == 0) begin
                    checkOutput("unexpectedResult", {60'd0, tag_o}, 64'hDEAD);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("result", {32'd0, result_o}, {32'd0, e.result});
                    checkOutput("tag", {60'd0, tag_o}, {60'd0, e.tag});
                    checkOutput("flags", {59'd0, zero_o, neg_o, carry_o, ovf_o, illegal_o}, {59'd0, e.flags});
                    if (e.checkLat) checkOutput("latency", 64'(cycle), 64'(e.dueCycle));
                end
            end
        end
    end

    initial begin
        #200000;
        errCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        dataA_i    = '0;
        dataB_i    = '0;
        op_i       = '0;
        tag_i      = '0;
        repeat (3) @(negedge clk_i);
        checkResetOutputs("reset");
        rst_i = 1'b0;
        #1;
        checkOutput("readyAfterReset", {63'd0, in_ready_o}, 64'd1);

        $display("[TB] add with carry-out wrap");
        applyStimulus(4'b0010, 32'hFFFFFFFF, 32'd1, 4'd3, 1);
        idle();
        #1;
        checkOutput("notYetValid", {63'd0, out_valid_o}, 64'd0);
        drain();

        $display("[TB] back-to-back sub overflow and slt");
        applyStimulus(4'b0110, 32'h80000000, 32'd1, 4'd5, 1);
        applyStimulus(4'b0111, 32'hFFFFFFFF, 32'd0, 4'd6, 1);
        idle();
        drain();

        $display("[TB] shifts and misc ops");
        applyStimulus(4'b1011, 32'h80000010, 32'h24, 4'd7, 1);
        applyStimulus(4'b1001, 32'h80000010, 32'h24, 4'd8, 1);
        applyStimulus(4'b1010, 32'h80000010, 32'h24, 4'd1, 1);
        applyStimulus(4'b1001, 32'h12345678, 32'h20, 4'd2, 1);
        applyStimulus(4'b1000, 32'h00000001, 32'hFFFFFFFF, 4'd4, 1);
        applyStimulus(4'b0100, 32'h0F0F0000, 32'h000000F0, 4'd12, 1);
        applyStimulus(4'b0011, 32'hAAAA5555, 32'hAAAA5555, 4'd13, 1);
        applyStimulus(4'b0010, 32'h7FFFFFFF, 32'd1, 4'd14, 1);
        idle();
        drain();

        $display("[TB] illegal and optional multiply opcodes");
        applyStimulus(4'b1101, 32'h5, 32'h5, 4'd9, 1);
        applyStimulus(4'b1100, 32'd7, 32'd6, 4'd10, 1);
        applyStimulus(4'b0101, 32'h0, 32'h0, 4'd11, 1);
        idle();
        drain();

        $display("[TB] random operations");
        for (int i = 0; i < 12; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            applyStimulus(rop, $urandom, $urandom, 4'(i), 1);
        end
        idle();
        drain();

        $display("[TB] stream of 5 with output stall");
        stallStart = cycle + 3;
        stallEnd   = cycle + 7;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, 32'(100 * i), 32'(i + 1), 4'(i + 1), 0);
        end
        idle();
        drain();
        stallStart = 1000000;
        stallEnd   = -1;

        $display("[TB] reset with operations in flight");
        applyStimulus(4'b0001, 32'h11, 32'h22, 4'd6, 0);
        applyStimulus(4'b0001, 32'h33, 32'h44, 4'd7, 0);
        #1;
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        #1;
        checkResetOutputs("midReset");
        sbQ.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("readyAfterMidReset", {63'd0, in_ready_o}, 64'd1);
        applyStimulus(4'b0000, 32'hF0, 32'h3C, 4'd11, 1);
        idle();
        drain();
        repeat (4) @(negedge clk_i);
        #1;
        checkOutput("noStale", {63'd0, out_valid_o}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's single-cycle 32-bit ALU.
- Generalises operand width and pipeline latency.
- Adds a valid/ready handshake on both sides, a pass-through tag, shifts, set-less-than ops, and full status flags (zero/negative/carry/overflow/illegal).
- Sits between the decode/issue stage and writeback in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of 2).
- LATENCY, 2, pipeline register stages from input accept to result (1..4).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  operation presented.
- in_ready_o  out  1  block can accept an operation this cycle.
- dataA_i  in  WIDTH  operand A.
- dataB_i  in  WIDTH  operand B; for shifts, bits [log2(WIDTH)-1:0] are the shift amount.
- op_i  in  4  operation code.
- tag_i  in  TAG_W  tag, returned unchanged.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  ALU result.
- tag_o  out  TAG_W  tag of the result.
- zero_o  out  1  result == 0.
- neg_o  out  1  result[WIDTH-1].
- carry_o  out  1  ADD: carry out; SUB: borrow (A<B unsigned); otherwise 0.
- ovf_o  out  1  signed overflow for ADD/SUB; otherwise 0.
- illegal_o  out  1  op_i was an undefined code.

Behaviour:
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SLTU (unsigned, 0/1), 1001 SLL, 1010 SRL, 1011 SRA (arithmetic). All other codes are illegal.
- Illegal op: result 0, zero_o=0, neg_o=0, carry_o=0, ovf_o=0, illegal_o=1; still handshaken and counted like any operation.
- Arithmetic is modulo 2^WIDTH.
- Flags are computed in stage 1 from the full-width result and travel with it.
- Shifts use B mod WIDTH; a shift of 0 returns A.
- Pipeline: LATENCY stages, each with a valid bit plus data/tag/flags.
  - Operation accepted on a cycle with in_valid_i & in_ready_o.
  - Result appears on out_valid_o exactly LATENCY cycles later when there is no stall.
- Stall (global): stall = out_valid_o & ~out_ready_i; in_ready_o = ~stall.
  - While stalled, all stages hold their contents and the outputs stay stable.
  - Bubbles are not compressed.
- Throughput: one operation per cycle while out_ready_i=1.
- Result handshake: out_valid_o stays high and result_o/flags/tag_o stay stable until out_valid_o & out_ready_i.
- No ordering change: results return in accept order.
- Inputs with in_valid_i=0 create a bubble (stage valid=0). Data registers in bubble stages may hold stale values, but out_valid_o must be 0.
- Reset (async, any time, including mid-pipeline):
  - All stage valids cleared; in-flight operations are discarded.
  - out_valid_o=0, result_o=0, tag_o=0, zero_o=1, neg_o=0, carry_o=0, ovf_o=0, illegal_o=0.
  - in_ready_o=1 from the first cycle after reset deasserts.
- Simultaneous accept and stall is impossible by construction: in_ready_o is low whenever stall is high.
- out_ready_i is ignored while out_valid_o=0.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: opcode 1100 = MUL, result = low WIDTH bits of unsigned A*B.
  - zero_o and neg_o computed from the result; carry_o=0, ovf_o=0.
  - Latency is still LATENCY; the multiplier may be split across stages.
- Undefined: 1100 is illegal (illegal_o=1, result 0) and no multiplier logic is synthesised.

Test Plan (WIDTH=32, LATENCY=2):
1. Reset released, then ADD A=0xFFFFFFFF B=1 tag=3 -> 2 cycles later out_valid_o=1, result 0, zero_o=1, carry_o=1, ovf_o=0, tag_o=3.
2. SUB A=0x80000000 B=1, then SLT A=0xFFFFFFFF B=0 back-to-back, out_ready_i=1:
   - first result 0x7FFFFFFF, ovf_o=1, carry_o=0;
   - second result 1 one cycle later.
3. SRA A=0x80000010 B=0x24 -> result 0xF8000001 (shift 4); SLL same operands -> 0x00000100.
4. op=1101 -> result 0, illegal_o=1, zero_o=0. op=1100 -> with ALU_PIPE_MUL_EN, A=7 B=6 gives 42; without it, illegal_o=1.
5. Stream 5 ops with out_ready_i=0 from cycle 3 to cycle 7:
   - in_ready_o=0 during the stall; the head result is held stable;
   - all 5 results are delivered in order with correct tags; none are lost or duplicated.
6. Assert rst_i while 2 ops are in flight -> outputs immediately at reset values. After release, a new AND A=0xF0 B=0x3C gives 0x30, and no stale result appears.
